// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage of the 8-bit CPU.
// The decode and control stages use the same opcode and state definitions.
package fetch_unit_pkg;

    localparam int ADDR_W   = 8;
    localparam int INSTR_W  = 10;
    localparam int OPCODE_W = 4;

    localparam logic [ADDR_W-1:0]   RESET_PC = 8'h00;
    localparam logic [OPCODE_W-1:0] HALT_OP  = 4'b1111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPCODE_W] == HALT_OP;
    endfunction

endpackage

// File: rtl/fetch_unit_program_counter.sv
// Program counter register: a load of an explicit target wins over increment,
// and the value holds when neither is requested.
module program_counter
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_pc;
        end else if (inc_en) begin
            // Natural modulo-2^ADDR_W wrap: 8'hFF advances to 8'h00.
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the async instruction memory and
// hands a one-entry fetch register to decode over a valid/ready handshake.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               halted
);

    // Handshake: an entry transfers on any rising edge where if_valid && if_ready.
    // if_valid, if_instr and if_pc stay stable until that transfer, unless a
    // redirect discards the entry.

    fetch_state_e       state_q, state_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ifpc_q,  ifpc_d;
    logic [ADDR_W-1:0]  pc;
    logic               load;

    program_counter u_pc (
        .clk     (clk),
        .reset   (reset),
        .load_en (redirect_valid),
        .load_pc (redirect_pc),
        .inc_en  (load),
        .pc      (pc)
    );

    // Redirect suppresses the fetch so the stale sequential slot never lands.
    assign load = (state_q == ST_RUN) && (!valid_q || if_ready) && !redirect_valid;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        if (redirect_valid) begin
            state_d = ST_RUN;
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = imem_instr;
            ifpc_d  = pc;
            if (is_halt(imem_instr)) begin
                state_d = ST_HALT;
            end
        end else if (valid_q && if_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
        end
    end

    assign imem_addr = pc;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = ifpc_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the reference model is the stream of
// {pc, instr} pairs decode should receive, walked sequentially from each restart.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic               halted;

    logic [INSTR_W-1:0] mem [256];

    logic [17:0] exp_q[$];
    logic [7:0]  gen_pc;
    bit          gen_done;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          idle_cnt = 0;
    logic [17:0] mon_front;
    logic [7:0]  mon_next;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [INSTR_W-1:0] rand_plain();
        logic [3:0] op;
        logic [5:0] arg;
        op  = 4'($urandom_range(0, 14));
        arg = 6'($urandom_range(0, 63));
        return {op, arg};
    endfunction

    // Expected stream: sequential addresses from the restart point, ending
    // with (and including) the first HALT opcode.
    task automatic top_up();
        while (!gen_done && exp_q.size() < 4) begin
            exp_q.push_back({gen_pc, mem[gen_pc]});
            if (mem[gen_pc][9:6] == 4'hF) gen_done = 1'b1;
            gen_pc = gen_pc + 8'd1;
        end
    endtask

    task automatic restart(input logic [7:0] p);
        exp_q.delete();
        gen_pc   = p;
        gen_done = 1'b0;
        top_up();
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [7:0] tgt);
        if_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (redir) restart(tgt);
        else top_up();
    endtask

    task automatic check_reset_values();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC));
        chk("rst_if_pc", 32'(if_pc), 32'd0);
        chk("rst_if_instr", 32'(if_instr), 32'd0);
    endtask

    // Called just after a rising edge: asserts reset between edges and checks
    // that outputs clear before the next edge.
    task automatic async_reset();
        redirect_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values();
        restart(RESET_PC);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: everything presented must match the head of the expected stream.
    always @(negedge clk) begin
        if (reset) begin
            idle_cnt = 0;
        end else if (if_valid) begin
            idle_cnt = 0;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(if_valid), 32'd0);
            end else begin
                mon_front = exp_q[0];
                mon_next  = mon_front[17:10] + 8'd1;
                chk("if_pc", 32'(if_pc), 32'(mon_front[17:10]));
                chk("if_instr", 32'(if_instr), 32'(mon_front[9:0]));
                chk("imem_addr_valid", 32'(imem_addr), 32'(mon_next));
                chk("halted_valid", 32'(halted), 32'(mon_front[9:6] == 4'hF));
                if (if_ready) void'(exp_q.pop_front());
            end
        end else if (exp_q.size() == 0) begin
            idle_cnt = 0;
            chk("halted_drained", 32'(halted), 32'd1);
            chk("imem_addr_drained", 32'(imem_addr), 32'(gen_pc));
        end else begin
            chk("halted_idle", 32'(halted), 32'd0);
            chk("imem_addr_idle", 32'(imem_addr), 32'(exp_q[0][17:10]));
            idle_cnt = redirect_valid ? 0 : idle_cnt + 1;
            if (idle_cnt > 1) begin
                chk("fetch_bubble", 32'(idle_cnt), 32'd1);
                idle_cnt = 0;
            end
        end
    end

    initial begin
        reset          = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int i = 0; i < 256; i++) mem[i] = rand_plain();
        mem[0] = 10'b1001000001;
        mem[5] = {HALT_OP, 6'h00};

        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        restart(RESET_PC);
        if_ready = 1'b1;
        reset    = 1'b0;

        // Stream 0,1,2 then stall on pc 2.
        repeat (3) step(1'b1, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        // Redirect discards a stalled entry.
        step(1'b0, 1'b1, 8'h40);
        repeat (4) step(1'b1, 1'b0, 8'h00);
        // Redirect with a simultaneous transfer, then run into HALT at 5.
        step(1'b1, 1'b1, 8'h03);
        repeat (3) step(1'b1, 1'b0, 8'h00);
        repeat (2) step(1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b1, 1'b0, 8'h00);
        // Leave HALT, then wrap through FF -> 00.
        step(1'b1, 1'b1, 8'h10);
        repeat (3) step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hFE);
        repeat (5) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        async_reset();

        // Random phase over a fully random program (HALTs included).
        for (int i = 0; i < 256; i++) mem[i] = INSTR_W'($urandom_range(0, 1023));
        redirect_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        restart(RESET_PC);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 399) == 0) async_reset();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
